ghost_mode_scheduler: RTL

GHOST_MODE_SCHEDULER -- requirements
Module: ghost_mode_scheduler

---
 rtl/ghost_mode_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ghost_mode_scheduler.sv
// Ghost behaviour scheduler: global scatter/chase phase, frighten period, per-ghost death/respawn.
// Optional flash flag near the end of frighten is built only with GHOST_FRIGHT_FLASH_EN defined.

module ghost_lane #(
  parameter int DEAD_TICKS = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       pellet,
  input  logic       fright_end,
  input  logic       collide,
  input  logic [1:0] phase_mode,
  output logic [1:0] mode,
  output logic       eaten
);
  localparam logic [1:0] M_FRIGHT = 2'b01;
  localparam logic [1:0] M_DEAD   = 2'b10;
  localparam int DW = $clog2(DEAD_TICKS + 1);

  logic [DW-1:0] dead_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode     <= 2'b11;
      dead_cnt <= '0;
      eaten    <= 1'b0;
    end else begin
      eaten <= collide && (mode == M_FRIGHT);
      case (mode)
        M_DEAD: begin
          // Respawn always goes to the global phase, even mid-frighten.
          if (tick) begin
            dead_cnt <= dead_cnt - 1'b1;
            if (dead_cnt <= DW'(1)) begin
              mode     <= phase_mode;
              dead_cnt <= '0;
            end
          end
        end
        M_FRIGHT: begin
          if (collide) begin
            mode     <= M_DEAD;
            dead_cnt <= DW'(DEAD_TICKS);
          end else if (!pellet && fright_end) begin
            mode <= phase_mode;
          end
        end
        default: mode <= pellet ? M_FRIGHT : phase_mode;
      endcase
    end
  end
endmodule

module ghost_mode_scheduler #(
  parameter int SCATTER_TICKS = 420,
  parameter int CHASE_TICKS   = 1200,
  parameter int FRIGHT_TICKS  = 360,
  parameter int DEAD_TICKS    = 180,
  parameter int FLASH_TICKS   = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       pellet_eaten,
  input  logic [3:0] collide,
  output logic [7:0] ghost_mode,
  output logic       player_hit,
  output logic [3:0] ghost_eaten,
  output logic [1:0] eat_combo,
  output logic       fright_flash
);
  localparam int NUM_GHOSTS = 4;
  localparam int PMAX = (SCATTER_TICKS > CHASE_TICKS) ? SCATTER_TICKS : CHASE_TICKS;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int FMAX = (FRIGHT_TICKS > FLASH_TICKS) ? FRIGHT_TICKS : FLASH_TICKS;
  localparam int FW   = $clog2(FMAX + 1);

  typedef enum logic {SCATTER, CHASE} phase_t;

  phase_t                        phase, phase_nxt;
  logic [PW-1:0]                 phase_cnt;
  logic [FW-1:0]                 fright_cnt, fright_nxt;
  logic                          fright_active, phase_step, phase_wrap, fright_end;
  logic [NUM_GHOSTS-1:0][1:0]    modes;
  logic [1:0]                    phase_mode;
  logic [NUM_GHOSTS-1:0]         eat_now, hit_now;
  logic [2:0]                    eat_cnt, combo_sum;
  logic [1:0]                    combo_nxt;

  assign fright_active = (fright_cnt != '0);
  assign phase_step    = tick && !fright_active;
  assign phase_wrap    = phase_step &&
                         ((phase == SCATTER) ? (phase_cnt == PW'(SCATTER_TICKS - 1))
                                             : (phase_cnt == PW'(CHASE_TICKS - 1)));
  assign phase_nxt     = phase_wrap ? ((phase == SCATTER) ? CHASE : SCATTER) : phase;
  // Lanes take the post-transition phase so they follow it in the same edge as the FSM.
  assign phase_mode    = (phase_nxt == SCATTER) ? 2'b11 : 2'b00;
  assign fright_end    = tick && (fright_cnt == FW'(1)) && !pellet_eaten;
  assign ghost_mode    = modes;

  always_comb begin
    fright_nxt = fright_cnt;
    if (pellet_eaten)                fright_nxt = FW'(FRIGHT_TICKS);
    else if (tick && fright_active)  fright_nxt = fright_cnt - 1'b1;
  end

  always_comb begin
    eat_cnt = '0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      eat_now[i] = collide[i] && (modes[i] == 2'b01);
      hit_now[i] = collide[i] && (modes[i] == 2'b00 || modes[i] == 2'b11);
      eat_cnt    = eat_cnt + {2'b00, eat_now[i]};
    end
    combo_sum = (pellet_eaten ? 3'd0 : {1'b0, eat_combo}) + eat_cnt;
    combo_nxt = (combo_sum > 3'd3) ? 2'd3 : combo_sum[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= SCATTER;
      phase_cnt  <= '0;
      fright_cnt <= '0;
      eat_combo  <= '0;
      player_hit <= 1'b0;
    end else begin
      phase      <= phase_nxt;
      if (phase_wrap)      phase_cnt <= '0;
      else if (phase_step) phase_cnt <= phase_cnt + 1'b1;
      fright_cnt <= fright_nxt;
      eat_combo  <= combo_nxt;
      player_hit <= |hit_now;
    end
  end

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_lane
    ghost_lane #(.DEAD_TICKS(DEAD_TICKS)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .pellet     (pellet_eaten),
      .fright_end (fright_end),
      .collide    (collide[g]),
      .phase_mode (phase_mode),
      .mode       (modes[g]),
      .eaten      (ghost_eaten[g])
    );
  end

`ifdef GHOST_FRIGHT_FLASH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fright_flash <= 1'b0;
    else     fright_flash <= (fright_nxt != '0) && (fright_nxt <= FW'(FLASH_TICKS));
  end
`else
  assign fright_flash = 1'b0;
`endif
endmodule
